// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, stall hold buffer and redirect drain.
// Optional stall-cycle counter output enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int              SIZE     = 32,
  parameter logic [SIZE-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            CLR_N,
  input  logic            StallF,
  input  logic            PCSrcE,
  input  logic [SIZE-1:0] PCTargetE,
  input  logic            IMemRdy,
  input  logic [SIZE-1:0] IMemRData,
  output logic            IMemReq,
  output logic [SIZE-1:0] IMemAddr,
  output logic [SIZE-1:0] InstrF,
  output logic [SIZE-1:0] PCF,
  output logic [SIZE-1:0] PCPlus4F,
`ifdef FETCH_PERF_CNT_EN
  output logic [SIZE-1:0] FetchStallCnt,
`endif
  output logic            FetchBusyF
);

  // state | meaning
  // IDLE  | one cycle after reset release, no request
  // FETCH | request outstanding at PCF, instruction accepted when IMemRdy
  // HOLD  | decode stalled, instruction replayed from hold buffer
  // DRAIN | redirect taken while a request was pending, discard its data
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  localparam logic [SIZE-1:0] NOP     = SIZE'(32'h0000_0013);
  localparam logic [SIZE-1:0] PC_MASK = {{(SIZE-2){1'b1}}, 2'b00};

  state_t          state, state_nxt;
  logic [SIZE-1:0] pc_q, pc_nxt;
  logic [SIZE-1:0] hold_q, hold_nxt;
  logic [SIZE-1:0] redir_q, redir_nxt;
  logic [SIZE-1:0] tgt;

  assign tgt      = PCTargetE & PC_MASK;
  assign PCF      = pc_q;
  assign IMemAddr = pc_q;
  assign PCPlus4F = pc_q + SIZE'(4);

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state   <= IDLE;
      pc_q    <= RESET_PC & PC_MASK;
      hold_q  <= NOP;
      redir_q <= '0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      hold_q  <= hold_nxt;
      redir_q <= redir_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc_q;
    hold_nxt   = hold_q;
    redir_nxt  = redir_q;
    IMemReq    = 1'b0;
    FetchBusyF = 1'b1;
    InstrF     = NOP;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
        if (PCSrcE) pc_nxt = tgt;
      end
      FETCH: begin
        IMemReq = 1'b1;
        if (IMemRdy) begin
          InstrF     = IMemRData;
          FetchBusyF = 1'b0;
          hold_nxt   = IMemRData;
          if (PCSrcE)       pc_nxt = tgt;
          else if (!StallF) pc_nxt = PCPlus4F;
          else              state_nxt = HOLD;
        end else if (PCSrcE) begin
          redir_nxt = tgt;
          state_nxt = DRAIN;
        end
      end
      HOLD: begin
        InstrF     = hold_q;
        FetchBusyF = 1'b0;
        if (PCSrcE) begin
          pc_nxt    = tgt;
          state_nxt = FETCH;
        end else if (!StallF) begin
          pc_nxt    = PCPlus4F;
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        IMemReq = 1'b1;
        // a redirect arriving in the same cycle as the stale data still wins
        if (IMemRdy) begin
          pc_nxt    = PCSrcE ? tgt : redir_q;
          state_nxt = FETCH;
        end else if (PCSrcE) begin
          redir_nxt = tgt;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic [SIZE-1:0] stall_cnt;
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N)
      stall_cnt <= '0;
    else if (FetchBusyF && (state == FETCH || state == DRAIN) && stall_cnt != '1)
      stall_cnt <= stall_cnt + SIZE'(1);
  end
  assign FetchStallCnt = stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scripted cycles, accepted fetches scored against a queue.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        CLR_N = 1'b0;
  logic        StallF = 1'b0, PCSrcE = 1'b0, IMemRdy = 1'b1;
  logic [31:0] PCTargetE = '0, IMemRData;
  logic        IMemReq, FetchBusyF;
  logic [31:0] IMemAddr, InstrF, PCF, PCPlus4F;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchStallCnt;
`endif

  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = '0;
  int          errors = 0, checks = 0, exp_cnt = 0;
  logic [63:0] sb_q[$];

  fetch_unit #(.SIZE(32), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .StallF(StallF), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .IMemRdy(IMemRdy), .IMemRData(IMemRData),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .InstrF(InstrF), .PCF(PCF),
    .PCPlus4F(PCPlus4F),
`ifdef FETCH_PERF_CNT_EN
    .FetchStallCnt(FetchStallCnt),
`endif
    .FetchBusyF(FetchBusyF)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  always_comb IMemRData = ovr_en ? ovr_val : mem_word(IMemAddr);

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic stall, input logic pcsrc,
                      input logic [31:0] tgt);
    @(negedge CLK);
    IMemRdy = rdy; StallF = stall; PCSrcE = pcsrc; PCTargetE = tgt;
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    sb_q.push_back({a, d});
  endtask

  // scoreboard monitor: every accepted instruction must match the next expectation
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge CLK);
      #2;
      if (!CLR_N) exp_cnt = 0;
      else begin
        if (FetchBusyF && IMemReq) exp_cnt++;
        if (IMemReq && IMemRdy && !FetchBusyF) begin
          if (sb_q.size() == 0) chk("sb_unexpected_accept", {IMemAddr, InstrF}, 64'h0);
          else begin
            e = sb_q.pop_front();
            chk("sb_addr", {32'h0, IMemAddr}, {32'h0, e[63:32]});
            chk("sb_instr", {32'h0, InstrF}, {32'h0, e[31:0]});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_req", IMemReq, 0);
    chk("rst_busy", FetchBusyF, 1);
    chk("rst_instr", InstrF, NOP);
    chk("rst_pc", PCF, 32'h0);

    @(negedge CLK); CLR_N = 1'b1; #1;
    chk("idle_req", IMemReq, 0);
    chk("idle_busy", FetchBusyF, 1);
    chk("idle_instr", InstrF, NOP);

    // zero-wait streaming from reset
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      chk("seq_addr", IMemAddr, 32'(i * 4));
      chk("seq_busy", FetchBusyF, 0);
      chk("seq_pc4", PCPlus4F, 32'(i * 4 + 4));
      push(32'(i * 4), mem_word(32'(i * 4)));
    end

    // three wait states at 0x10
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("wait_busy", FetchBusyF, 1);
      chk("wait_instr", InstrF, NOP);
      chk("wait_req", IMemReq, 1);
      chk("wait_pc", PCF, 32'h10);
    end
    step(1, 0, 0, 0);
    chk("wait_accept_busy", FetchBusyF, 0);
    push(32'h10, mem_word(32'h10));

    // accepted branch back to 0x8
    step(1, 0, 1, 32'h8);
    chk("wait_next_pc", PCF, 32'h14);
    push(32'h14, mem_word(32'h14));

    // stall with data returned: hold buffer replays it
    @(negedge CLK);
    IMemRdy = 1; StallF = 1; PCSrcE = 0; PCTargetE = 0;
    ovr_en = 1; ovr_val = 32'hDEAD_BEEF; #1;
    chk("stall_pc", PCF, 32'h8);
    chk("stall_instr", InstrF, 32'hDEAD_BEEF);
    push(32'h8, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      step(1, (i < 2) ? 1'b1 : 1'b0, 0, 0);
      ovr_en = 0; #1;
      chk("hold_instr", InstrF, 32'hDEAD_BEEF);
      chk("hold_req", IMemReq, 0);
      chk("hold_busy", FetchBusyF, 0);
      chk("hold_pc", PCF, 32'h8);
    end

    // redirect while waiting, then a second redirect in DRAIN
    step(0, 0, 1, 32'h100);
    chk("drain_entry_pc", PCF, 32'hC);
    chk("drain_entry_busy", FetchBusyF, 1);
    step(0, 0, 1, 32'h200);
    chk("drain_req", IMemReq, 1);
    chk("drain_busy", FetchBusyF, 1);
    chk("drain_instr", InstrF, NOP);
    step(1, 0, 0, 0);
    chk("drain_discard_instr", InstrF, NOP);
    chk("drain_discard_busy", FetchBusyF, 1);
    step(1, 1, 0, 0);
    chk("redir_addr", IMemAddr, 32'h200);
    push(32'h200, mem_word(32'h200));

    // redirect beats stall in HOLD, low target bits dropped
    step(1, 1, 1, 32'h43);
    chk("hold_redir_in_hold", IMemReq, 0);
    step(1, 0, 0, 0);
    chk("hold_redir_pc", PCF, 32'h40);
    chk("hold_redir_req", IMemReq, 1);
    push(32'h40, mem_word(32'h40));

    // reset asserted in the middle of DRAIN
    step(0, 0, 1, 32'h80);
    step(0, 0, 0, 0);
    chk("pre_rst_drain_req", IMemReq, 1);
    #2;
    CLR_N = 1'b0; exp_cnt = 0; #1;
    chk("midrst_pc", PCF, 32'h0);
    chk("midrst_req", IMemReq, 0);
    chk("midrst_busy", FetchBusyF, 1);
    @(negedge CLK); CLR_N = 1'b1; #1;
    chk("post_rst_idle_req", IMemReq, 0);
    step(1, 0, 0, 0);
    chk("post_rst_addr", IMemAddr, 32'h0);
    push(32'h0, mem_word(32'h0));

    // wrap at top of address space
    step(1, 0, 1, 32'hFFFF_FFFF);
    push(32'h4, mem_word(32'h4));
    step(1, 0, 0, 0);
    chk("wrap_pc", PCF, 32'hFFFF_FFFC);
    chk("wrap_pc4", PCPlus4F, 32'h0);
    push(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
    step(1, 0, 0, 0);
    chk("wrap_next_pc", PCF, 32'h0);
    push(32'h0, mem_word(32'h0));

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    #3;
    chk("sb_empty", sb_q.size(), 0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_cnt", FetchStallCnt, exp_cnt);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
